// File: rtl/reg_serializer.sv
// Parallel-to-serial register reader with valid/ready on both sides.
// Define REG_SERIALIZER_PARITY_EN to append an even-parity beat per word.
module reg_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);

`ifdef REG_SERIALIZER_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(SW - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state, state_n;
    logic [SW-1:0]   sh, sh_n, load_vec, sh_adv;
    logic [CW-1:0]   cnt, cnt_n;
    logic            sout_n, valid_n, last_n, ready_n, busy_n;

    function automatic logic out_bit(input logic [SW-1:0] v);
        return MSB_FIRST ? v[SW-1] : v[0];
    endfunction

    // Parity rides in the shift register right behind the last data bit.
`ifdef REG_SERIALIZER_PARITY_EN
    assign load_vec = MSB_FIRST ? {din, ^din} : {^din, din};
`else
    assign load_vec = din;
`endif

    assign sh_adv = MSB_FIRST ? {sh[SW-2:0], 1'b0} : {1'b0, sh[SW-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            din_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            cnt        <= cnt_n;
            sout       <= sout_n;
            sout_valid <= valid_n;
            sout_last  <= last_n;
            din_ready  <= ready_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        sout_n  = sout;
        valid_n = sout_valid;
        last_n  = sout_last;
        ready_n = din_ready;
        busy_n  = busy;
        unique case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (din_valid && din_ready) begin
                    sh_n    = load_vec;
                    cnt_n   = LOAD_CNT;
                    ready_n = 1'b0;
                    valid_n = 1'b1;
                    sout_n  = out_bit(load_vec);
                    last_n  = (LOAD_CNT == '0);
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (sout_valid && sout_ready) begin
                    if (sout_last) begin
                        sh_n    = '0;
                        cnt_n   = '0;
                        sout_n  = 1'b0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                        ready_n = 1'b1;
                        state_n = IDLE;
                    end else if (cnt != '0) begin
                        sh_n   = sh_adv;
                        cnt_n  = cnt - CW'(1);
                        sout_n = out_bit(sh_adv);
                        last_n = (cnt == CW'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Randomized bench for reg_serializer: MSB- and LSB-first instances
// share stimulus and are checked against a per-word expected bit list.
module tb_reg_serializer;

    localparam int W = 8;
`ifdef REG_SERIALIZER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         sout_ready = 1'b0;

    logic rdy_m, s_m, sv_m, sl_m, busy_m;
    logic rdy_l, s_l, sv_l, sl_l, busy_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy_m),
        .sout      (s_m),
        .sout_valid(sv_m),
        .sout_ready(sout_ready),
        .sout_last (sl_m),
        .busy      (busy_m)
    );

    reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy_l),
        .sout      (s_l),
        .sout_valid(sv_l),
        .sout_ready(sout_ready),
        .sout_last (sl_l),
        .busy      (busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat i of a word as the link should carry it; index W is parity.
    function automatic logic exp_bit(input logic [W-1:0] w, input bit msb,
                                     input int i);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_sv"}, {sv_m, sv_l}, 2'b00);
        chk({tag, "_sout"}, {s_m, s_l}, 2'b00);
        chk({tag, "_last"}, {sl_m, sl_l}, 2'b00);
        chk({tag, "_busy"}, {busy_m, busy_l}, 2'b00);
    endtask

    task automatic do_abort();
        reset = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort_rdy", {rdy_m, rdy_l}, 2'b00);
        din_valid  = 1'b0;
        sout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called just after a negedge. abort_at >= 0 resets after that many beats.
    task automatic xfer(input logic [W-1:0] w, input int stall_pct,
                        input logic [15:0] stall2, input int abort_at,
                        output int cycles);
        int guard = 0;
        cycles = 0;
        while (!rdy_m && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", {rdy_m, rdy_l}, 2'b11);
        chk_quiet("idle");
        din        = w;
        din_valid  = 1'b1;
        sout_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            int  held = 0;
            int  stalls;
            bit  go;
            stalls = stall2[i] ? 2 : 0;
            do begin
                chk("valid", {sv_m, sv_l}, 2'b11);
                chk("sout_msb", s_m, exp_bit(w, 1'b1, i));
                chk("sout_lsb", s_l, exp_bit(w, 1'b0, i));
                chk("last", {sl_m, sl_l}, (i == NB - 1) ? 2'b11 : 2'b00);
                chk("busy", {busy_m, busy_l}, 2'b11);
                chk("rdy_busy", {rdy_m, rdy_l}, 2'b00);
                if (abort_at >= 0 && i == abort_at) begin
                    do_abort();
                    return;
                end
                if (stall2 != '0) go = (held >= stalls);
                else go = ($urandom_range(0, 99) >= stall_pct) || held >= 8;
                held++;
                sout_ready = go;
                din_valid  = (i < NB - 1) ? 1'($urandom) : 1'b0;
                din        = W'($urandom);
                @(posedge clk);
                cycles++;
                @(negedge clk);
            end while (!go);
        end
        din_valid  = 1'b0;
        sout_ready = 1'b0;
        chk_quiet("done");
        chk("done_rdy", {rdy_m, rdy_l}, 2'b11);
    endtask

    initial begin
        int cyc;
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_quiet("rst");
            chk("rst_rdy", {rdy_m, rdy_l}, 2'b00);
        end
        reset = 1'b1;
        #1;
        chk("rel_rdy", {rdy_m, rdy_l}, 2'b00);
        @(negedge clk);
        chk("rel_rdy_up", {rdy_m, rdy_l}, 2'b11);
        chk("rel_busy", {busy_m, busy_l}, 2'b00);

        xfer(8'hA5, 0, '0, -1, cyc);
        chk("a5_cycles", cyc, NB);

        xfer(8'h3C, 0, 16'h0012, -1, cyc);
        chk("3c_cycles", cyc, NB + 4);

        xfer(8'hFF, 40, '0, -1, cyc);
        xfer(8'h00, 0, '0, -1, cyc);
        chk("00_cycles", cyc, NB);

        xfer(8'hF0, 0, '0, 3, cyc);
        xfer(8'h81, 0, '0, -1, cyc);
        chk("81_cycles", cyc, NB);

        xfer(8'h07, 0, '0, -1, cyc);

        for (int k = 0; k < 24; k++) begin
            int ab;
            ab = (k == 11) ? int'($urandom_range(0, NB - 1)) : -1;
            xfer(W'($urandom), 30, '0, ab, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
